inst_fetch: RTL and testbench

Instruction-fetch controller for the teaching CPU. It owns the program counter, drives the chip-enable and word address of the 64×32 instruction ROM, and registers each returned word together with its PC for the decode stage. It handles pipeline stalls, branch redirects with flush, and a sticky fault on misaligned branch targets.

---
 rtl/inst_fetch_if.sv | 34 +++
 rtl/inst_fetch.sv | 88 ++++++++
 tb/tb_inst_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if
//   Bundles the fetch-stage signals that run between the instruction-fetch
//   controller, the instruction ROM and the decode stage.
//   master : held by inst_fetch. It drives the ROM request and the decode
//            outputs, and it receives stall, branch and ROM data.
//   slave  : held by the surroundings (pipeline control, ROM, decode).
//   Signals:
//     stall_i, branch_flag_i, branch_target_i : pipeline control toward fetch
//     rom_ce_o, rom_addr_o / rom_inst_i       : ROM request / read data
//     pc_o, inst_o, inst_valid_o, fault_o     : registered fetch results
interface inst_fetch_if #(
    parameter int ADDR_W = 6
);
    logic              stall_i;
    logic              branch_flag_i;
    logic [31:0]       branch_target_i;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [31:0]       rom_inst_i;
    logic [31:0]       pc_o;
    logic [31:0]       inst_o;
    logic              inst_valid_o;
    logic              fault_o;

    modport master (
        input  stall_i, branch_flag_i, branch_target_i, rom_inst_i,
        output rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o, fault_o
    );

    modport slave (
        output stall_i, branch_flag_i, branch_target_i, rom_inst_i,
        input  rom_ce_o, rom_addr_o, pc_o, inst_o, inst_valid_o, fault_o
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction-fetch controller. It owns the program counter and drives the
//   ROM chip enable and word address combinationally. It registers each
//   returned word together with its byte PC for decode. It also handles
//   stalls, branch redirects with flush, and a sticky fault on misaligned
//   branch targets.
//   Ports:
//     clk  : system clock. All state updates happen on the rising edge.
//     rst  : synchronous, active-high reset.
//     bus  : inst_fetch_if.master. Carries the stall and branch inputs, the
//            ROM request and data, and the decode outputs.
//   Parameters:
//     ADDR_W   : ROM word-address width. It must match the interface.
//     RESET_PC : word-aligned PC that reset loads.
module inst_fetch #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    // ROM request has no register stage. Only the low word-address bits
    // reach the ROM, so fetch wraps every 2^(ADDR_W+2) bytes.
    assign bus.rom_ce_o     = (state == FETCH);
    assign bus.rom_addr_o   = pc[ADDR_W+1:2];
    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = valid_q;
    assign bus.fault_o      = (state == FAULT);

    // In FETCH a branch outranks a stall. A misaligned target outranks an
    // aligned one and locks the unit in FAULT until reset. When the fault
    // is entered, valid and inst are cleared, and they stay cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            pc_q    <= 32'd0;
            inst_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (bus.branch_flag_i && (bus.branch_target_i[1:0] != 2'b00)) begin
                        state   <= FAULT;
                        inst_q  <= 32'd0;
                        valid_q <= 1'b0;
                    end else if (bus.branch_flag_i) begin
                        // Flush the word currently being fetched. pc_o keeps
                        // the PC of the last delivered word.
                        pc      <= bus.branch_target_i;
                        inst_q  <= 32'd0;
                        valid_q <= 1'b0;
                    end else if (!bus.stall_i) begin
                        inst_q  <= bus.rom_inst_i;
                        pc_q    <= pc;
                        valid_q <= 1'b1;
                        pc      <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    state   <= FAULT;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
//   Directed plus randomized bench for inst_fetch. It holds a 64-word ROM
//   array and a cycle-level reference model of the fetch behaviour. After
//   every clock edge it compares all DUT outputs with that model.
module tb_inst_fetch;

    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] rom [64];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: phase 0 = waiting after reset, 1 = running,
    // 2 = faulted.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_pc_o;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_fault;

    inst_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // The ROM is combinational from the address and returns 0 while disabled.
    assign bus.rom_inst_i = bus.rom_ce_o ? rom[bus.rom_addr_o] : 32'd0;

    task automatic check_one(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance the reference model by one edge, using the inputs that were
    // present before that edge.
    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
        if (r) begin
            m_phase = 0; m_pc = 32'h0; m_pc_o = 0; m_inst = 0; m_valid = 0; m_fault = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (b && t[1:0] != 2'b00) begin
                m_phase = 2; m_fault = 1; m_valid = 0; m_inst = 0;
            end else if (b) begin
                m_pc = t; m_valid = 0; m_inst = 0;
            end else if (!s) begin
                m_inst  = rom[(m_pc / 4) % 64];
                m_pc_o  = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic checkOutput();
        check_one("inst_o",       bus.inst_o,             m_inst);
        check_one("pc_o",         bus.pc_o,               m_pc_o);
        check_one("inst_valid_o", {31'd0, bus.inst_valid_o}, {31'd0, m_valid});
        check_one("fault_o",      {31'd0, bus.fault_o},      {31'd0, m_fault});
        check_one("rom_ce_o",     {31'd0, bus.rom_ce_o},     {31'd0, (m_phase == 1)});
        if (m_phase == 1)
            check_one("rom_addr_o", {26'd0, bus.rom_addr_o}, (m_pc / 4) % 64);
    endtask

    // Drive one cycle of inputs, clock once, then update the model and check.
    task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst                 = r;
        bus.stall_i         = s;
        bus.branch_flag_i   = b;
        bus.branch_target_i = t;
        @(posedge clk);
        #1;
        model_step(r, s, b, t);
        checkOutput();
    endtask

    initial begin
        logic r, s, b;
        logic [31:0] t;

        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        bus.stall_i = 0; bus.branch_flag_i = 0; bus.branch_target_i = 0;
        m_phase = 0; m_pc = 0; m_pc_o = 0; m_inst = 0; m_valid = 0; m_fault = 0;

        $display("[TB] reset and run");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        check_one("idle_ce", {31'd0, bus.rom_ce_o}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        check_one("first_edge_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        check_one("first_inst", bus.inst_o, 32'h11);
        check_one("first_pc", bus.pc_o, 32'h0);
        applyStimulus(0, 0, 0, 0);
        check_one("second_inst", bus.inst_o, 32'h22);

        $display("[TB] stall holds");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            check_one("stall_hold_inst", bus.inst_o, 32'h22);
            check_one("stall_hold_pc", bus.pc_o, 32'h4);
        end
        applyStimulus(0, 0, 0, 0);
        check_one("after_stall_inst", bus.inst_o, 32'h33);
        check_one("after_stall_pc", bus.pc_o, 32'h8);

        $display("[TB] branch with stall");
        applyStimulus(0, 1, 1, 32'h20);
        check_one("branch_addr", {26'd0, bus.rom_addr_o}, 32'd8);
        applyStimulus(0, 0, 0, 0);
        check_one("branch_target_pc", bus.pc_o, 32'h20);
        check_one("branch_target_inst", bus.inst_o, rom[8]);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] address wrap");
        applyStimulus(0, 0, 1, 32'hF8);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        check_one("wrap_pc", bus.pc_o, 32'h100);
        check_one("wrap_inst", bus.inst_o, 32'h11);

        $display("[TB] reset with branch pending");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h40);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        check_one("restart_pc", bus.pc_o, 32'h0);
        check_one("restart_inst", bus.inst_o, 32'h11);

        $display("[TB] misaligned branch");
        applyStimulus(0, 0, 1, 32'h22);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, i[0], i[1], 32'h30);
            check_one("fault_sticky", {31'd0, bus.fault_o}, 32'd1);
        end
        applyStimulus(1, 0, 0, 0);
        check_one("fault_cleared", {31'd0, bus.fault_o}, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(r, s, b, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
